dot_product_mac: RTL

DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

---
 rtl/dot_product_mac_pkg.sv | 16 +
 rtl/dp_operand_ram.sv | 23 ++
 rtl/dot_product_mac.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dot_product_mac_pkg.sv
// Shared FSM encoding and default parameter values for dot_product_mac.
package dot_product_mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_SIGNED = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/dp_operand_ram.sv
// Single-write, single-registered-read operand buffer; contents are never reset.
module dp_operand_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dot_product_mac.sv
// Buffered dot-product engine: RAM read -> product register -> accumulate.
// Define DOT_PRODUCT_MAC_SAT_EN for a saturating accumulator (default wraps).
module dot_product_mac
    import dot_product_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SIGNED = DEF_SIGNED
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data_a,
    input  logic [DATA_W-1:0]          wr_data_b,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           result,
    output logic                       overflow
);

    localparam int   AW     = $clog2(DEPTH);
    localparam int   PW     = 2 * DATA_W;
    localparam int   STAGES = 1;
    localparam logic SGN    = (SIGNED != 0);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t            state;
    logic [AW-1:0]     rd_addr, last_addr;
    logic              drain_cnt;
    logic [STAGES:0]   vld_pipe;
    logic [ACC_W-1:0]  acc;
    logic [PW-1:0]     prod_q;

    logic              rd_en, wr_ok;
    logic [AW:0]       len_eff, len_m1;
    logic [DATA_W-1:0] a_dat, b_dat;
    logic [PW-1:0]     a_x, b_x, prod_d;
    logic [ACC_W:0]    acc_x, prod_x, sum;
    logic              add_ovf;
    logic [ACC_W-1:0]  sat_val, acc_nxt;

    assign busy    = (state != ST_IDLE);
    assign rd_en   = (state == ST_RUN);
    assign wr_ok   = wr_en && (state == ST_IDLE);
    assign len_eff = (len > DEPTH_L) ? DEPTH_L : len;
    assign len_m1  = len_eff - 1'b1;

    dp_operand_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram_a (
        .clk(clk), .we(wr_ok), .waddr(wr_addr), .wdata(wr_data_a),
        .re(rd_en), .raddr(rd_addr), .rdata(a_dat)
    );

    dp_operand_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram_b (
        .clk(clk), .we(wr_ok), .waddr(wr_addr), .wdata(wr_data_b),
        .re(rd_en), .raddr(rd_addr), .rdata(b_dat)
    );

    // Low PW bits of the product of sign/zero-extended operands give the exact product.
    assign a_x    = {{DATA_W{SGN & a_dat[DATA_W-1]}}, a_dat};
    assign b_x    = {{DATA_W{SGN & b_dat[DATA_W-1]}}, b_dat};
    assign prod_d = a_x * b_x;

    // One guard bit above ACC_W exposes carry-out (unsigned) or sign disagreement (signed).
    assign acc_x   = {SGN & acc[ACC_W-1], acc};
    assign prod_x  = {{(ACC_W+1-PW){SGN & prod_q[PW-1]}}, prod_q};
    assign sum     = acc_x + prod_x;
    assign add_ovf = SGN ? (sum[ACC_W] != sum[ACC_W-1]) : sum[ACC_W];
    assign sat_val = !SGN        ? {ACC_W{1'b1}} :
                     sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                   {1'b0, {(ACC_W-1){1'b1}}};

`ifdef DOT_PRODUCT_MAC_SAT_EN
    assign acc_nxt = overflow ? acc : (add_ovf ? sat_val : sum[ACC_W-1:0]);
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (vld_pipe[0]) prod_q <= prod_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            last_addr <= '0;
            drain_cnt <= 1'b0;
            vld_pipe  <= '0;
            acc       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_en};
            if (vld_pipe[STAGES]) begin
                acc <= acc_nxt;
                if (add_ovf) overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        overflow  <= 1'b0;
                        rd_addr   <= '0;
                        last_addr <= len_m1[AW-1:0];
                        state     <= (len_eff == '0) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_addr == last_addr) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) state <= ST_FINISH;
                    drain_cnt <= 1'b1;
                end
                ST_FINISH: begin
                    done   <= 1'b1;
                    result <= acc;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
